// File: rtl/qam_demapper.sv
// Hard-decision 16-QAM demapper.
// Registers one signed I/Q sample per clock, slices it to a Gray-coded
// 4-bit symbol, and queues the symbols of a framed burst in a first-word
// fall-through FIFO for a downstream consumer.
module qam_demapper #(
    parameter int THRESH     = 64,
    parameter int FIFO_DEPTH = 16,
    parameter int FRAME_LEN  = 100
) (
    input  logic              symbol_clock,
    input  logic              rst,
    input  logic signed [7:0] I_in,
    input  logic signed [7:0] Q_in,
    input  logic              enable,
    input  logic              read,
    output logic [3:0]        data_out,
    output logic [3:0]        fifo_dout,
    output logic              available,
    output logic              complete,
    output logic              overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    localparam logic [PTR_W:0]        FULL_LVL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]      LAST_SYM = CNT_W'(FRAME_LEN - 1);
    localparam logic signed [7:0]     POS_T    = 8'(THRESH);
    localparam logic signed [7:0]     NEG_T    = 8'(-THRESH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Per-axis decision: four regions split at -THRESH, 0 and +THRESH,
    // Gray-coded so adjacent regions differ in one bit.
    function automatic logic [1:0] slice_axis(input logic signed [7:0] x);
        logic [1:0] s;
        if (x < NEG_T)
            s = 2'b00;
        else if (x < 8'sd0)
            s = 2'b01;
        else if (x < POS_T)
            s = 2'b11;
        else
            s = 2'b10;
        return s;
    endfunction

    logic signed [7:0]  i_p0;
    logic signed [7:0]  q_p0;
    logic [3:0]         in_sym;

    state_t             state;
    logic [CNT_W-1:0]   sym_cnt;

    logic [3:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     occ;

    logic               push;
    logic               pop;
    logic               full;
    logic               wr_ok;

    // Input capture stage: every edge, reset forces the all-zero sample.
    always_ff @(posedge symbol_clock) begin
        if (rst) begin
            i_p0 <= '0;
            q_p0 <= '0;
        end else begin
            i_p0 <= I_in;
            q_p0 <= Q_in;
        end
    end

    // The FIFO entry pushed on an edge is the same symbol data_out shows
    // after that edge, so it is sliced straight from the unregistered inputs.
    assign data_out = {slice_axis(i_p0), slice_axis(q_p0)};
    assign in_sym   = {slice_axis(I_in), slice_axis(Q_in)};

    assign push  = (state == RUN) && enable;
    assign pop   = read && (occ != '0);
    assign full  = (occ == FULL_LVL);
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign wr_ok = push && (!full || pop);

    // Burst framing FSM with registered completion flag.
    always_ff @(posedge symbol_clock) begin
        if (rst) begin
            state    <= IDLE;
            sym_cnt  <= '0;
            complete <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable)
                        state <= RUN;
                end
                RUN: begin
                    if (!enable) begin
                        state <= DRAIN;
                    end else begin
                        sym_cnt <= sym_cnt + 1'b1;
                        if (sym_cnt == LAST_SYM)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (occ == '0) begin
                        state    <= DONE;
                        complete <= 1'b1;
                    end
                end
                DONE: begin
                    if (!enable) begin
                        state    <= IDLE;
                        sym_cnt  <= '0;
                        complete <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // FIFO storage: data only, contents are meaningless until pointed at.
    always_ff @(posedge symbol_clock) begin
        if (!rst && wr_ok)
            mem[wr_ptr] <= in_sym;
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge symbol_clock) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && full && !pop)
                overflow <= 1'b1;
            case ({wr_ok, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    assign available = (occ != '0);
    assign fifo_dout = available ? mem[rd_ptr] : 4'h0;

endmodule

// File: tb/tb_qam_demapper.sv
// Bench for qam_demapper: two instances (short and long frames) share the
// I/Q stream; a queue-style reference model predicts every output each cycle.
module tb_qam_demapper;

    localparam int THRESH = 64;
    localparam int DEPTH  = 16;
    localparam int FL_A   = 4;
    localparam int FL_B   = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic signed [7:0] i_s, q_s;
    logic              en_a, rd_a, en_b, rd_b;
    logic [3:0]        dout_a, fdout_a, dout_b, fdout_b;
    logic              avail_a, cmp_a, ovf_a, avail_b, cmp_b, ovf_b;

    qam_demapper #(.THRESH(THRESH), .FIFO_DEPTH(DEPTH), .FRAME_LEN(FL_A)) dut_a (
        .symbol_clock(clk), .rst(rst), .I_in(i_s), .Q_in(q_s),
        .enable(en_a), .read(rd_a), .data_out(dout_a), .fifo_dout(fdout_a),
        .available(avail_a), .complete(cmp_a), .overflow(ovf_a));

    qam_demapper #(.THRESH(THRESH), .FIFO_DEPTH(DEPTH), .FRAME_LEN(FL_B)) dut_b (
        .symbol_clock(clk), .rst(rst), .I_in(i_s), .Q_in(q_s),
        .enable(en_b), .read(rd_b), .data_out(dout_b), .fifo_dout(fdout_b),
        .available(avail_b), .complete(cmp_b), .overflow(ovf_b));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: index 0 follows dut_a, index 1 follows dut_b.
    int         m_phase [2];
    int         m_cnt   [2];
    int         m_size  [2];
    bit         m_ovf   [2];
    logic [3:0] m_fifo  [2][DEPTH];
    logic [3:0] m_last;

    typedef struct {
        int         i;
        int         q;
        logic [3:0] exp;
    } vec_t;
    vec_t tbl [7];

    logic [3:0] exp_sym [4];
    logic [3:0] first_sym;

    function automatic logic [1:0] ax(input logic signed [7:0] x);
        int v;
        v = int'(x);
        if (v < -THRESH) return 2'b00;
        if (v < 0)       return 2'b01;
        if (v < THRESH)  return 2'b11;
        return 2'b10;
    endfunction

    function automatic logic [3:0] slice(input logic signed [7:0] i, input logic signed [7:0] q);
        return {ax(i), ax(q)};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Burst semantics: start on enable, accept while enabled up to the frame
    // length, then wait for an empty queue, then hold done until enable drops.
    task automatic model_edge(input int k, input bit r, input bit en, input bit rd,
                              input logic [3:0] sym);
        int fl;
        bit pop;
        bit push;
        fl = (k == 0) ? FL_A : FL_B;
        if (r) begin
            m_phase[k] = 0;
            m_cnt[k]   = 0;
            m_size[k]  = 0;
            m_ovf[k]   = 0;
            return;
        end
        pop  = rd && (m_size[k] > 0);
        push = 0;
        case (m_phase[k])
            0: if (en) m_phase[k] = 1;
            1: begin
                if (!en) m_phase[k] = 2;
                else begin
                    push = 1;
                    m_cnt[k]++;
                    if (m_cnt[k] == fl) m_phase[k] = 2;
                end
            end
            2: if (m_size[k] == 0) m_phase[k] = 3;
            default: if (!en) begin m_phase[k] = 0; m_cnt[k] = 0; end
        endcase
        if (pop) begin
            for (int j = 0; j < DEPTH - 1; j++) m_fifo[k][j] = m_fifo[k][j+1];
            m_size[k]--;
        end
        if (push) begin
            if (m_size[k] < DEPTH) begin
                m_fifo[k][m_size[k]] = sym;
                m_size[k]++;
            end else begin
                m_ovf[k] = 1;
            end
        end
    endtask

    task automatic check_all();
        check("a_data_out",  dout_a,  m_last);
        check("b_data_out",  dout_b,  m_last);
        check("a_available", {3'b0, avail_a}, {3'b0, m_size[0] > 0});
        check("b_available", {3'b0, avail_b}, {3'b0, m_size[1] > 0});
        check("a_fifo_dout", fdout_a, (m_size[0] > 0) ? m_fifo[0][0] : 4'h0);
        check("b_fifo_dout", fdout_b, (m_size[1] > 0) ? m_fifo[1][0] : 4'h0);
        check("a_complete",  {3'b0, cmp_a}, {3'b0, m_phase[0] == 3});
        check("b_complete",  {3'b0, cmp_b}, {3'b0, m_phase[1] == 3});
        check("a_overflow",  {3'b0, ovf_a}, {3'b0, m_ovf[0]});
        check("b_overflow",  {3'b0, ovf_b}, {3'b0, m_ovf[1]});
    endtask

    // One clock: model consumes the inputs seen at the edge, outputs checked 1ns later.
    task automatic tick();
        logic [3:0] sym;
        sym = slice(i_s, q_s);
        @(posedge clk);
        model_edge(0, rst, en_a, rd_a, sym);
        model_edge(1, rst, en_b, rd_b, sym);
        m_last = rst ? 4'hF : sym;
        #1;
        check_all();
    endtask

    task automatic rand_iq();
        i_s = 8'($urandom);
        q_s = 8'($urandom);
    endtask

    initial begin
        tbl[0] = '{-128, -128, 4'h0};
        tbl[1] = '{-64,  -65,  4'h4};
        tbl[2] = '{-1,   0,    4'h7};
        tbl[3] = '{63,   64,   4'hE};
        tbl[4] = '{127,  -1,   4'h9};
        tbl[5] = '{0,    0,    4'hF};
        tbl[6] = '{-65,  64,   4'h2};

        rst = 1'b1; i_s = 8'sd37; q_s = -8'sd90;
        en_a = 1'b0; rd_a = 1'b0; en_b = 1'b0; rd_b = 1'b0;

        // Reset state
        tick();
        check("rst_data_out",  dout_a, 4'hF);
        check("rst_available", {3'b0, avail_a}, 4'h0);
        check("rst_complete",  {3'b0, cmp_a}, 4'h0);
        check("rst_overflow",  {3'b0, ovf_a}, 4'h0);
        check("rst_fifo_dout", fdout_a, 4'h0);
        rst = 1'b0;

        // Slicer boundary table
        for (int n = 0; n < 7; n++) begin
            i_s = 8'(tbl[n].i);
            q_s = 8'(tbl[n].q);
            tick();
            check($sformatf("slice_vec%0d", n), dout_a, tbl[n].exp);
        end

        // Mixed sweep of 100 vectors with edge values sprinkled in
        for (int n = 0; n < 100; n++) begin
            rand_iq();
            if (n % 10 == 0) i_s = 8'(-THRESH + (n / 10) - 5);
            if (n % 10 == 1) q_s = 8'(THRESH + (n / 10) - 5);
            if (n == 50) begin i_s = 8'sd0; q_s = 8'sd0; end
            tick();
        end

        // Short burst then drain through the read handshake
        rst = 1'b1; tick(); rst = 1'b0;
        en_a = 1'b1; rd_a = 1'b0;
        for (int n = 0; n < 6; n++) begin
            rand_iq();
            if (n >= 1 && n <= 4) exp_sym[n-1] = slice(i_s, q_s);
            tick();
        end
        check("burst_available", {3'b0, avail_a}, 4'h1);
        rd_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("burst_pop%0d", k), fdout_a, exp_sym[k]);
            tick();
        end
        check("burst_empty",        {3'b0, avail_a}, 4'h0);
        check("burst_not_complete", {3'b0, cmp_a}, 4'h0);
        tick();
        check("burst_complete",     {3'b0, cmp_a}, 4'h1);
        en_a = 1'b0; rd_a = 1'b0;
        tick();
        check("done_to_idle",       {3'b0, cmp_a}, 4'h0);

        // Overflow: 20 symbols into 16 slots with no reads
        rst = 1'b1; tick(); rst = 1'b0;
        en_b = 1'b1; rd_b = 1'b0;
        for (int n = 0; n < 21; n++) begin
            rand_iq();
            if (n == 1) first_sym = slice(i_s, q_s);
            tick();
            if (n == 16) check("ovf_at_full", {3'b0, ovf_b}, 4'h0);
        end
        check("ovf_set",       {3'b0, ovf_b}, 4'h1);
        check("ovf_head_kept", fdout_b, first_sym);

        // Push and pop together while full keeps the FIFO full without overflow
        rst = 1'b1; tick(); rst = 1'b0;
        en_b = 1'b1; rd_b = 1'b0;
        for (int n = 0; n < 17; n++) begin rand_iq(); tick(); end
        rd_b = 1'b1;
        for (int n = 0; n < 2; n++) begin rand_iq(); tick(); end
        check("full_pushpop_no_ovf", {3'b0, ovf_b}, 4'h0);
        rd_b = 1'b0;
        rand_iq(); tick();
        check("full_after_pushpop", {3'b0, ovf_b}, 4'h1);
        en_b = 1'b0;

        // Reset in the middle of a burst
        rst = 1'b1; tick(); rst = 1'b0;
        en_a = 1'b1; rd_a = 1'b0;
        for (int n = 0; n < 4; n++) begin rand_iq(); tick(); end
        check("midrun_has_data", {3'b0, avail_a}, 4'h1);
        rst = 1'b1; i_s = 8'sd100; q_s = -8'sd100;
        tick();
        rst = 1'b0;
        check("midrun_rst_avail", {3'b0, avail_a}, 4'h0);
        check("midrun_rst_dout",  dout_a, 4'hF);
        check("midrun_rst_fdout", fdout_a, 4'h0);
        rand_iq(); tick();
        check("midrun_idle_first", {3'b0, avail_a}, 4'h0);
        rand_iq(); tick();
        check("midrun_restart",    {3'b0, avail_a}, 4'h1);

        // Randomised traffic on both instances against the model
        for (int n = 0; n < 800; n++) begin
            rand_iq();
            rst  = ($urandom_range(0, 99) == 0);
            en_a = ($urandom_range(0, 9) < 8);
            en_b = ($urandom_range(0, 9) < 8);
            rd_a = $urandom_range(0, 1) == 1;
            rd_b = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
